regarray_sequencer: RTL and testbench

Multi-cycle instruction sequencer that drives the 8×14-bit register array: decodes one 14-bit instruction at a time and generates its write enables (`ldR`, `ldALU`) and read selects (`selrd1`, `selrd2`, `selram`). It also handshakes with the ALU (start/done) and the data RAM (req/ack). It sits between the instruction fetch stage and the register array / ALU / RAM datapath, and it is the only block that writes the array.

---
 rtl/regarray_sequencer.sv | 156 +++++++++++++++
 tb/tb_regarray_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regarray_sequencer.sv
// Instruction sequencer for the 8x14 register array.
// Decodes one instruction at a time; handshakes with ALU and data RAM.
module regarray_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        alu_done,
  input  logic        mem_ack,
  output logic [7:0]  ldR,
  output logic [7:0]  ldALU,
  output logic [2:0]  selrd1,
  output logic [2:0]  selrd2,
  output logic [2:0]  selram,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  output logic        mem_req,
  output logic        mem_we,
  output logic        rin_sel,
  output logic [13:0] imm_out,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, DECODE, EXEC_ALU, WB_ALU,
    MEM, WB_MEM, WB_IMM, HALT
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT - 1);

  state_t      state;
  logic [13:0] ir;
  logic [7:0]  cnt;
  logic [3:0]  opc;
  logic [7:0]  rd_hot;
  logic        is_nop;
  logic        is_alu;
  logic        is_load;
  logic        is_store;
  logic        is_ldi;
  logic        is_halt;

  assign opc      = ir[13:10];
  assign rd_hot   = 8'd1 << ir[9:7];
  assign is_nop   = (opc == 4'b0000);
  assign is_alu   = !opc[3] && !is_nop;
  assign is_load  = (opc == 4'b1000);
  assign is_store = (opc == 4'b1001);
  assign is_ldi   = (opc == 4'b1010);
  assign is_halt  = (opc == 4'b1111);

  assign instr_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ir        <= '0;
      cnt       <= '0;
      ldR       <= '0;
      ldALU     <= '0;
      selrd1    <= '0;
      selrd2    <= '0;
      selram    <= '0;
      alu_op    <= '0;
      alu_start <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      rin_sel   <= 1'b0;
      imm_out   <= '0;
      halted    <= 1'b0;
      err       <= 1'b0;
    end else begin
      // write enables and the start strobe are single-cycle pulses
      ldR       <= '0;
      ldALU     <= '0;
      alu_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= DECODE;
          end
        end
        DECODE: begin
          selrd1  <= ir[6:4];
          selrd2  <= ir[3:1];
          selram  <= ir[3:1];
          alu_op  <= ir[12:10];
          imm_out <= {7'd0, ir[6:0]};
          rin_sel <= is_ldi;
          cnt     <= '0;
          state   <= IDLE;
          unique case (1'b1)
            is_nop: state <= IDLE;
            is_alu: begin
              alu_start <= 1'b1;
              state     <= EXEC_ALU;
            end
            is_load, is_store: begin
              mem_req <= 1'b1;
              mem_we  <= is_store;
              state   <= MEM;
            end
            is_ldi: begin
              ldR   <= rd_hot;
              state <= WB_IMM;
            end
            is_halt: begin
              halted <= 1'b1;
              state  <= HALT;
            end
            default: err <= 1'b1;
          endcase
        end
        EXEC_ALU: begin
          if (alu_done) begin
            ldALU <= rd_hot;
            state <= WB_ALU;
          end else if (cnt == TMO) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (is_load) begin
              ldR   <= rd_hot;
              state <= WB_MEM;
            end else begin
              state <= IDLE;
            end
          end else if (cnt == TMO) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WB_ALU, WB_MEM, WB_IMM: state <= IDLE;
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regarray_sequencer.sv
// Scoreboard bench for regarray_sequencer: directed instructions,
// expected writebacks queued at issue and matched by a monitor.
module tb_regarray_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        alu_done = 1'b0;
  logic        mem_ack = 1'b0;
  logic [7:0]  ldR;
  logic [7:0]  ldALU;
  logic [2:0]  selrd1;
  logic [2:0]  selrd2;
  logic [2:0]  selram;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        mem_req;
  logic        mem_we;
  logic        rin_sel;
  logic [13:0] imm_out;
  logic        halted;
  logic        err;

  regarray_sequencer #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .alu_done(alu_done), .mem_ack(mem_ack),
    .ldR(ldR), .ldALU(ldALU),
    .selrd1(selrd1), .selrd2(selrd2), .selram(selram),
    .alu_op(alu_op), .alu_start(alu_start),
    .mem_req(mem_req), .mem_we(mem_we),
    .rin_sel(rin_sel), .imm_out(imm_out),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] a;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  starts = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  // monitor: every writeback the DUT presents must match the queue head
  always @(negedge clk) begin
    if (rst && alu_start) starts++;
    if (rst && (ldR != 0 || ldALU != 0)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {16'd0, ldR, ldALU}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_ldR", {24'd0, ldR}, {24'd0, mon_e.r});
        chk("wb_ldALU", {24'd0, ldALU}, {24'd0, mon_e.a});
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic issue(input logic [13:0] i);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", {31'd0, instr_ready}, 32'd1);
    instr = i;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_ldR", {24'd0, ldR}, 32'd0);
    chk("rst_ldALU", {24'd0, ldALU}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_imm", {18'd0, imm_out}, 32'd0);
    rst = 1'b1;
  endtask

  int n;
  int s0;
  int mreq;

  initial begin
    do_reset();

    // LDI rd=3 imm=0x55
    exp_q.push_back('{r: 8'h08, a: 8'h00});
    issue(14'h29D5);
    smp();
    chk("ldi_busy", {31'd0, instr_ready}, 32'd0);
    nxt(); smp();
    chk("ldi_rin_sel", {31'd0, rin_sel}, 32'd1);
    chk("ldi_imm", {18'd0, imm_out}, 32'h55);
    chk("ldi_ldR_t2", {24'd0, ldR}, 32'h08);
    nxt(); smp();
    chk("ldi_ldR_t3", {24'd0, ldR}, 32'h00);
    chk("ldi_ready_t3", {31'd0, instr_ready}, 32'd1);

    // ALU op 010 rd=5 rs1=1 rs2=2, done 3 cycles after start
    s0 = starts;
    exp_q.push_back('{r: 8'h00, a: 8'h20});
    issue(14'h0A94);
    nxt(); smp();
    chk("alu_start", {31'd0, alu_start}, 32'd1);
    chk("alu_selrd1", {29'd0, selrd1}, 32'd1);
    chk("alu_selrd2", {29'd0, selrd2}, 32'd2);
    chk("alu_op", {29'd0, alu_op}, 32'd2);
    nxt(); nxt(); nxt();
    alu_done = 1'b1;
    smp();
    chk("alu_no_early_wb", {24'd0, ldALU}, 32'd0);
    nxt();
    alu_done = 1'b0;
    smp();
    chk("alu_ldALU", {24'd0, ldALU}, 32'h20);
    nxt(); smp();
    chk("alu_ready", {31'd0, instr_ready}, 32'd1);
    chk("alu_one_start", starts - s0, 32'd1);

    // LOAD rd=7 rs1=4, ack 4 cycles after request starts
    exp_q.push_back('{r: 8'h80, a: 8'h00});
    issue(14'h23C0);
    mreq = 0;
    for (int i = 0; i < 5; i++) begin
      nxt();
      if (i == 4) mem_ack = 1'b1;
      smp();
      if (mem_req) mreq++;
      chk("load_we", {31'd0, mem_we}, 32'd0);
    end
    chk("load_selrd1", {29'd0, selrd1}, 32'd4);
    nxt();
    mem_ack = 1'b0;
    smp();
    chk("load_req_len", mreq, 32'd5);
    chk("load_req_drop", {31'd0, mem_req}, 32'd0);
    chk("load_ldR", {24'd0, ldR}, 32'h80);

    // STORE rs1=4 rs2=6, ack in the first MEM cycle
    issue(14'h244C);
    nxt();
    mem_ack = 1'b1;
    smp();
    chk("store_req", {31'd0, mem_req}, 32'd1);
    chk("store_we", {31'd0, mem_we}, 32'd1);
    chk("store_selram", {29'd0, selram}, 32'd6);
    nxt();
    mem_ack = 1'b0;
    smp();
    chk("store_req_drop", {31'd0, mem_req}, 32'd0);
    chk("store_ready", {31'd0, instr_ready}, 32'd1);

    // NOP
    issue(14'h0000);
    smp();
    chk("nop_busy", {31'd0, instr_ready}, 32'd0);
    nxt(); smp();
    chk("nop_ready", {31'd0, instr_ready}, 32'd1);

    // ALU op 001 rd=2 with no alu_done: timeout
    issue(14'h0500);
    n = 0;
    while (n < 300) begin
      nxt(); smp();
      if (err) break;
      n++;
    end
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_window", {31'd0, (n >= 254 && n <= 256)}, 32'd1);
    chk("tmo_ready", {31'd0, instr_ready}, 32'd1);
    nxt(); smp();
    chk("tmo_err_sticky", {31'd0, err}, 32'd1);

    // illegal opcode 1100
    do_reset();
    issue(14'h3000);
    nxt(); smp();
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_ready", {31'd0, instr_ready}, 32'd1);

    // reset in the middle of a LOAD
    issue(14'h23C0);
    nxt(); nxt(); smp();
    chk("rl_req_before", {31'd0, mem_req}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rl_req_async", {31'd0, mem_req}, 32'd0);
    chk("rl_ready_async", {31'd0, instr_ready}, 32'd1);
    chk("rl_selrd1_async", {29'd0, selrd1}, 32'd0);
    chk("rl_err_clr", {31'd0, err}, 32'd0);
    smp();
    rst = 1'b1;

    // HALT, then instructions are refused
    issue(14'h3C00);
    nxt(); smp();
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_ready", {31'd0, instr_ready}, 32'd0);
    instr = 14'h29D5;
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt(); smp();
      chk("halt_stays", {30'd0, halted, instr_ready}, 32'd2);
    end
    instr_valid = 1'b0;
    nxt(); smp();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
